// File: rtl/layer_tile_scheduler_pkg.sv
// Shared definitions for the layer tile scheduler:
// FSM encoding and default dimensions.
package layer_tile_scheduler_pkg;
  localparam int DIM_W = 8;
  localparam int MAX_OUTSTANDING = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/layer_tile_scheduler_index.sv
// Three-level nested tile index counter.
// c is innermost, then w, then h.
module tile_index_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [DIM_W-1:0] i_cfg_h,
  input  logic [DIM_W-1:0] i_cfg_w,
  input  logic [DIM_W-1:0] i_cfg_c,
  output logic [DIM_W-1:0] o_h,
  output logic [DIM_W-1:0] o_w,
  output logic [DIM_W-1:0] o_c,
  output logic             o_last
);
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_c;
  logic             w_h_end;
  logic             w_w_end;
  logic             w_c_end;

  assign w_h_end = (r_h == i_cfg_h - DIM_W'(1));
  assign w_w_end = (r_w == i_cfg_w - DIM_W'(1));
  assign w_c_end = (r_c == i_cfg_c - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_h <= '0;
      r_w <= '0;
      r_c <= '0;
    end else if (i_adv) begin
      if (!w_c_end) begin
        r_c <= r_c + DIM_W'(1);
      end else begin
        r_c <= '0;
        if (!w_w_end) begin
          r_w <= r_w + DIM_W'(1);
        end else begin
          r_w <= '0;
          r_h <= w_h_end ? '0 : r_h + DIM_W'(1);
        end
      end
    end
  end

  assign o_h    = r_h;
  assign o_w    = r_w;
  assign o_c    = r_c;
  assign o_last = w_h_end && w_w_end && w_c_end;
endmodule

// File: rtl/layer_tile_scheduler.sv
// Walks one layer's tile space and issues credit-limited
// tile requests to the compute engine.
module layer_tile_scheduler #(
  parameter int DIM_W = layer_tile_scheduler_pkg::DIM_W,
  parameter int MAX_OUTSTANDING =
    layer_tile_scheduler_pkg::MAX_OUTSTANDING,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIM_W-1:0] cfg_tiles_h_i,
  input  logic [DIM_W-1:0] cfg_tiles_w_i,
  input  logic [DIM_W-1:0] cfg_tiles_c_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [DIM_W-1:0] tile_h_o,
  output logic [DIM_W-1:0] tile_w_o,
  output logic [DIM_W-1:0] tile_c_o,
  output logic             tile_last_o,
  input  logic             tile_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  import layer_tile_scheduler_pkg::*;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DIM_W-1:0] r_cfg_h;
  logic [DIM_W-1:0] r_cfg_w;
  logic [DIM_W-1:0] r_cfg_c;
  logic [CNT_W-1:0] r_out;
  logic [CNT_W-1:0] w_out_nxt;
  logic             r_err;
  logic             w_start;
  logic             w_zero;
  logic             w_hs;
  logic             w_dec;
  logic             w_last;

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_zero  = (cfg_tiles_h_i == '0) ||
                   (cfg_tiles_w_i == '0) ||
                   (cfg_tiles_c_i == '0);

  // Credit check uses the registered count only.
  assign tile_valid_o = (r_state == S_ISSUE) &&
    (r_out < CNT_W'(MAX_OUTSTANDING));
  assign w_hs  = tile_valid_o && tile_ready_i;
  assign w_dec = tile_done_i && (r_out != '0);

  always_comb begin
    w_out_nxt = r_out;
    if (w_hs && !w_dec) begin
      w_out_nxt = r_out + CNT_W'(1);
    end else if (!w_hs && w_dec) begin
      w_out_nxt = r_out - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_zero ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_hs && w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_nxt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cfg_h <= '0;
      r_cfg_w <= '0;
      r_cfg_c <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (w_start) begin
        r_cfg_h <= cfg_tiles_h_i;
        r_cfg_w <= cfg_tiles_w_i;
        r_cfg_c <= cfg_tiles_c_i;
        r_err   <= 1'b0;
      end else if (tile_done_i && r_out == '0) begin
        r_err <= 1'b1;
      end
    end
  end

  tile_index_counter #(
    .DIM_W (DIM_W)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_adv   (w_hs),
    .i_cfg_h (r_cfg_h),
    .i_cfg_w (r_cfg_w),
    .i_cfg_c (r_cfg_c),
    .o_h     (tile_h_o),
    .o_w     (tile_w_o),
    .o_c     (tile_c_o),
    .o_last  (w_last)
  );

  assign tile_last_o = tile_valid_o && w_last;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = r_err;
endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Randomized self-checking bench for layer_tile_scheduler
// against a queue-based tile sequence and credit model.
module tb_layer_tile_scheduler;
  localparam int MO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] cfg_h, cfg_w, cfg_c;
  logic       tile_valid_o;
  logic       tile_ready_i;
  logic [7:0] tile_h_o, tile_w_o, tile_c_o;
  logic       tile_last_o;
  logic       tile_done_i;
  logic       busy_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_tile_scheduler #(
    .DIM_W           (8),
    .MAX_OUTSTANDING (MO),
    .CNT_W           (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .cfg_tiles_h_i (cfg_h),
    .cfg_tiles_w_i (cfg_w),
    .cfg_tiles_c_i (cfg_c),
    .tile_valid_o  (tile_valid_o),
    .tile_ready_i  (tile_ready_i),
    .tile_h_o      (tile_h_o),
    .tile_w_o      (tile_w_o),
    .tile_c_o      (tile_c_o),
    .tile_last_o   (tile_last_o),
    .tile_done_i   (tile_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start_i = 1'b0;
    tile_ready_i = 1'b0;
    tile_done_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    cfg_h = 8'd0; cfg_w = 8'd0; cfg_c = 8'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++;
    if ({tile_valid_o, tile_last_o, busy_o, done_o, err_o} !== 5'b0 ||
        {tile_h_o, tile_w_o, tile_c_o} !== 24'd0) begin
      bad++;
      $display("FAIL reset v=%b l=%b b=%b d=%b e=%b idx=%h/%h/%h exp all 0",
               tile_valid_o, tile_last_o, busy_o, done_o, err_o,
               tile_h_o, tile_w_o, tile_c_o);
    end
  endtask

  // Full layer against the model: nested-loop tile order,
  // credit = handshakes minus completions, done one cycle
  // after the model has nothing left.
  task automatic run_layer(input int h, input int w, input int c,
                           input int rdy_pct, input int stall_idx,
                           input int dlat, input bit poke,
                           input string name);
    int eh[$], ew[$], ec[$], due[$];
    int n, issued, outs, stall, hs_cnt;
    bit fin, hs, dn, exp_v, exp_d;
    n = h * w * c;
    issued = 0; outs = 0; stall = 0; fin = 0; hs_cnt = 0;
    for (int a = 0; a < h; a++)
      for (int b = 0; b < w; b++)
        for (int d = 0; d < c; d++) begin
          eh.push_back(a); ew.push_back(b); ec.push_back(d);
        end
    idle_inputs();
    cfg_h = 8'(h); cfg_w = 8'(w); cfg_c = 8'(c);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      tile_ready_i = ($urandom_range(99) < rdy_pct);
      if (issued == stall_idx && stall < 5) begin
        tile_ready_i = 1'b0;
        stall++;
      end
      dn = (due.size() > 0 && due[0] == k);
      if (dn) void'(due.pop_front());
      tile_done_i = dn;
      start_i = poke && (k == 3);
      if (start_i) begin
        cfg_h = 8'($urandom_range(1, 9));
        cfg_w = 8'($urandom_range(1, 9));
        cfg_c = 8'($urandom_range(0, 9));
      end
      #1;
      exp_v = (issued < n) && (outs < MO);
      exp_d = (issued == n) && (outs == 0);
      total++;
      if (tile_valid_o !== exp_v) begin
        bad++;
        $display("FAIL %s valid k=%0d got=%b exp=%b", name, k,
                 tile_valid_o, exp_v);
      end
      total++;
      if (done_o !== exp_d || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL %s done/busy k=%0d got=%b/%b exp=%b/1", name, k,
                 done_o, busy_o, exp_d);
      end
      if (tile_valid_o && issued < n) begin
        total++;
        if (tile_h_o !== 8'(eh[issued]) || tile_w_o !== 8'(ew[issued]) ||
            tile_c_o !== 8'(ec[issued]) ||
            tile_last_o !== (issued == n - 1)) begin
          bad++;
          $display("FAIL %s tile #%0d got=%0d,%0d,%0d l=%b exp=%0d,%0d,%0d l=%b",
                   name, issued, tile_h_o, tile_w_o, tile_c_o, tile_last_o,
                   eh[issued], ew[issued], ec[issued], issued == n - 1);
        end
      end
      hs = tile_valid_o && tile_ready_i;
      if (done_o) fin = 1'b1;
      tick();
      start_i = 1'b0;
      if (hs) begin
        issued++; outs++; hs_cnt++;
        due.push_back(k + dlat);
      end
      if (dn) outs--;
    end
    idle_inputs();
    total++;
    if (!fin || hs_cnt != n) begin
      bad++;
      $display("FAIL %s finish fin=%b handshakes=%0d exp=%0d", name,
               fin, hs_cnt, n);
    end
    total++;
    if ({busy_o, done_o, err_o, tile_valid_o} !== 4'b0) begin
      bad++;
      $display("FAIL %s after b=%b d=%b e=%b v=%b exp 0", name,
               busy_o, done_o, err_o, tile_valid_o);
    end
  endtask

  task automatic test_order;
    run_layer(2, 2, 2, 100, -1, 2, 1'b0, "order");
  endtask

  task automatic test_credit;
    run_layer(1, 1, 4, 100, -1, 10, 1'b0, "credit");
  endtask

  task automatic test_backpressure;
    run_layer(2, 2, 2, 100, 1, 2, 1'b0, "bp");
  endtask

  task automatic test_midlayer_start;
    run_layer(2, 2, 2, 100, -1, 2, 1'b1, "poke");
  endtask

  task automatic test_zero;
    idle_inputs();
    cfg_h = 8'd3; cfg_w = 8'd2; cfg_c = 8'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if ({done_o, busy_o, tile_valid_o} !== 3'b110) begin
      bad++;
      $display("FAIL zero k+1 d=%b b=%b v=%b exp 1/1/0",
               done_o, busy_o, tile_valid_o);
    end
    tick();
    total++;
    if ({done_o, busy_o, tile_valid_o} !== 3'b000) begin
      bad++;
      $display("FAIL zero k+2 d=%b b=%b v=%b exp 0/0/0",
               done_o, busy_o, tile_valid_o);
    end
  endtask

  task automatic test_err;
    idle_inputs();
    tile_done_i = 1'b1;
    tick();
    tile_done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL err_sticky i=%0d err=%b busy=%b exp 1/0",
                 i, err_o, busy_o);
      end
      tick();
    end
    cfg_h = 8'd1; cfg_w = 8'd1; cfg_c = 8'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clear err=%b exp 0", err_o);
    end
    tile_ready_i = 1'b1;
    tick();
    tile_ready_i = 1'b0;
    tile_done_i = 1'b1;
    tick();
    tile_done_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_layer done=%b err=%b exp 1/0", done_o, err_o);
    end
    tick();
  endtask

  task automatic test_midlayer_reset;
    int hs_cnt;
    bit saw_done;
    idle_inputs();
    cfg_h = 8'd2; cfg_w = 8'd2; cfg_c = 8'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 40 && hs_cnt < 3; k++) begin
      tile_ready_i = 1'b1;
      tile_done_i = (k >= 1 && k <= 2);
      #1;
      if (tile_valid_o) hs_cnt++;
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (hs_cnt != 3 ||
        {tile_valid_o, tile_last_o, busy_o, done_o, err_o} !== 5'b0 ||
        {tile_h_o, tile_w_o, tile_c_o} !== 24'd0) begin
      bad++;
      $display("FAIL rst_mid hs=%0d v=%b b=%b d=%b e=%b idx=%h/%h/%h exp 3,0",
               hs_cnt, tile_valid_o, busy_o, done_o, err_o,
               tile_h_o, tile_w_o, tile_c_o);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done_o || busy_o) saw_done = 1'b1;
      tick();
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL rst_nodone saw done/busy=%b exp 0", saw_done);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_layer($urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(40, 100), -1,
                $urandom_range(1, 4), 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_credit();
    test_backpressure();
    test_zero();
    test_err();
    test_midlayer_start();
    test_midlayer_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_tile_scheduler.md
Name: layer_tile_scheduler

Overview:
Consumes the single-cycle start pulse produced by the start-strobe edge-capture stage. It walks the tile index space of one accelerator layer and issues tile requests to the conv compute engine over a valid/ready handshake. A credit limit bounds the number of outstanding tiles. It reports busy, a one-cycle done pulse and a sticky protocol error.

Parameters:
DIM_W, 8, width of each tile-count config field and tile index output
MAX_OUTSTANDING, 2, maximum issued-but-not-completed tiles (1..15)
CNT_W, 4, width of the outstanding counter; must hold MAX_OUTSTANDING

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start_i  in  1  one-cycle start pulse
cfg_tiles_h_i  in  DIM_W  tile rows; sampled only on accepted start
cfg_tiles_w_i  in  DIM_W  tile columns; sampled only on accepted start
cfg_tiles_c_i  in  DIM_W  channel groups; sampled only on accepted start
tile_valid_o  out  1  tile request valid
tile_ready_i  in  1  compute engine accepts request
tile_h_o  out  DIM_W  row index of the current request
tile_w_o  out  DIM_W  column index of the current request
tile_c_o  out  DIM_W  channel-group index of the current request
tile_last_o  out  1  current request is the final tile of the layer
tile_done_i  in  1  one-cycle completion pulse from compute, one per tile
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  one-cycle layer-complete pulse
err_o  out  1  sticky: tile_done_i received with zero outstanding

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; all outputs 0; counters, indices and latched config cleared. Reset mid-layer aborts the layer immediately; no done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE. busy_o = (state != IDLE). done_o = (state == DONE). Both are registered.
- IDLE:
  - start_i=1: latch cfg, clear indices and err_o.
  - If any cfg field is 0, go to DONE.
  - Otherwise go to ISSUE.
- start_i in any state other than IDLE is ignored, with no effect on cfg or err_o.
- Index order: c innermost, then w, then h. All indices start at 0.
- tile_last_o = (h==H-1 && w==W-1 && c==C-1). It is valid only while tile_valid_o is high.
- ISSUE:
  - tile_valid_o = (outstanding < MAX_OUTSTANDING).
  - Once valid is high, valid and indices hold stable until tile_ready_i=1. Valid never drops without a handshake.
  - On handshake: outstanding +1 and indices advance.
  - On handshake of the last tile: go to DRAIN and clear valid.
- DRAIN: tile_valid_o=0. When outstanding reaches 0, go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Outstanding counter:
  - Handshake alone: +1.
  - tile_done_i alone: -1.
  - Both in the same cycle: unchanged.
  - The ISSUE valid check uses the registered count, so a same-cycle completion does not open a credit until the next cycle.
- Last tile and its completion in the same cycle with outstanding=1: net outstanding 1 → DRAIN, then DONE after the next completion. DRAIN → DONE is decided on the post-update count, so a done in the final DRAIN cycle yields DONE on the next cycle.
- tile_done_i with outstanding=0, in any state: counter stays 0 (no underflow) and err_o is set. err_o is cleared only by rst or an accepted start.
- Latency from start pulse sampled at edge k:
  - Normal config: ISSUE and tile_valid_o high from k+1.
  - Zero config: done_o high in cycle k+1 with no tiles issued.
- Total tiles issued = H*W*C. Maximum is (2^DIM_W - 1)^3; no counter wraps.

Decomposition:
- Shared accelerator package holds: the FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3), DIM_W, and the MAX_OUTSTANDING default.
- One sub-module, tile_index_counter: a 3-level nested counter taking an advance input and producing indices plus the last flag.
- FSM and credit logic stay in the top module.

Test Plan:
- cfg H=2,W=2,C=2, ready tied 1, tile_done_i 2 cycles after each handshake:
  - 8 requests in order (0,0,0),(0,0,1),(0,1,0)…(1,1,1).
  - tile_last_o only on (1,1,1).
  - done_o is one pulse; err_o=0.
- cfg H=1,W=1,C=4, no tile_done_i:
  - exactly 2 handshakes, then valid stays 0.
  - After two done pulses the remaining 2 tiles issue, then done_o.
- Backpressure: ready low for 5 cycles on tile (0,0,1) → valid and indices stable throughout; exactly one handshake when ready rises.
- cfg C=0 with start at edge k → done_o=1 at k+1, tile_valid_o never 1, busy_o high for 1 cycle only.
- tile_done_i in IDLE → err_o=1 and stays set; next accepted start clears it.
- Mid-layer: start_i pulsed during ISSUE is ignored with the sequence unchanged. rst asserted after 3 tiles → all outputs 0 next cycle and no done_o.
